// File: rtl/uart_pkg.sv
// Shared defaults, bit-period derivation and tx FSM encoding for the UART word sender.
package uart_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_UART_BPS = 9600;

  // Clock cycles spent on one serial bit.
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // Bit-period counter width: wide enough for BPS_CNT, never narrower than 16.
  function automatic int calc_cnt_w(input int bps_cnt);
    int w;
    w = $clog2(bps_cnt);
    return (w < 16) ? 16 : w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..BPS_CNT-1 while enabled and flags the last cycle.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BPS_CNT = calc_bps_cnt(DEF_CLK_FREQ, DEF_UART_BPS),
  parameter int CNT_W   = calc_cnt_w(BPS_CNT)
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BPS_CNT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-run within a bit, restart at each boundary, hold at zero while disabled.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en)   cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CNT_W'(1);
  end

  assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_word_send.sv
// Sends a 16-bit word as two back-to-back 8N1 frames, low byte first.
module uart_word_send
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int UART_BPS = DEF_UART_BPS
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tx_start,
  input  logic [15:0] tx_data,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        byte_sel
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);

  tx_state_t   state, state_nxt;
  logic [15:0] word, word_nxt;
  logic [2:0]  bit_idx, idx_nxt, idx_inc;
  logic [7:0]  cur_byte;
  logic        txd_nxt, busy_nxt, done_nxt, sel_nxt;
  logic        bit_tick;

  assign cur_byte = byte_sel ? word[15:8] : word[7:0];
  assign idx_inc  = bit_idx + 3'd1;

  uart_bit_timer #(.BPS_CNT(BPS_CNT)) u_timer (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (state != ST_IDLE),
    .bit_tick (bit_tick)
  );

  // State and every output are registered, so the line never sees an input combinationally.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      word     <= '0;
      bit_idx  <= '0;
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      byte_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      word     <= word_nxt;
      bit_idx  <= idx_nxt;
      uart_txd <= txd_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
      byte_sel <= sel_nxt;
    end
  end

  // Next state plus the next line level; each value lands on the line at the bit boundary.
  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    idx_nxt   = bit_idx;
    txd_nxt   = uart_txd;
    busy_nxt  = tx_busy;
    sel_nxt   = byte_sel;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tx_start) begin
          state_nxt = ST_START;
          word_nxt  = tx_data;
          idx_nxt   = '0;
          txd_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          sel_nxt   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_nxt = ST_DATA;
          txd_nxt   = cur_byte[0];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_idx == 3'd7) begin
            state_nxt = ST_STOP;
            idx_nxt   = '0;
            txd_nxt   = 1'b1;
          end else begin
            idx_nxt   = idx_inc;
            txd_nxt   = cur_byte[idx_inc];
          end
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (!byte_sel) begin
            // Low byte done: high byte frame follows with no gap.
            state_nxt = ST_START;
            sel_nxt   = 1'b1;
            txd_nxt   = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
            sel_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            txd_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_word_send.sv
// Directed bench for uart_word_send: bit-exact line checks at BPS_CNT=16 plus a default-rate bit width check.
module tb_uart_word_send;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        tx_start = 1'b0;
  logic [15:0] tx_data = '0;
  logic        uart_txd, tx_busy, tx_done, byte_sel;

  logic        d_start = 1'b0;
  logic [15:0] d_data = '0;
  logic        d_txd, d_busy, d_done, d_sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  uart_word_send #(.CLK_FREQ(16), .UART_BPS(1)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .uart_txd (uart_txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .byte_sel (byte_sel)
  );

  uart_word_send u_dflt (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .tx_start (d_start),
    .tx_data  (d_data),
    .uart_txd (d_txd),
    .tx_busy  (d_busy),
    .tx_done  (d_done),
    .byte_sel (d_sel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line level for bit slot k (0..19) of word w.
  function automatic logic exp_bit(input logic [15:0] w, input int k);
    if (k == 0 || k == 10) return 1'b0;
    if (k == 9 || k == 19) return 1'b1;
    if (k < 9)             return w[k-1];
    return w[k-3];
  endfunction

  // Called #1 after an edge; leaves us #1 after the accepting edge.
  task automatic start_word(input logic [15:0] w);
    tx_data  = w;
    tx_start = 1'b1;
    @(posedge sys_clk); #1;
    tx_start = 1'b0;
    tx_data  = ~w;
    chk($sformatf("start txd %h", w), 32'(uart_txd), 32'd0);
    chk($sformatf("start busy %h", w), 32'(tx_busy), 32'd1);
  endtask

  // Walks bit slots 0..stop_k-1, checking first and last cycle of each; optional stray tx_start.
  task automatic watch_word(input logic [15:0] w, input int inj_k, input int stop_k);
    for (int k = 0; k < stop_k; k++) begin
      for (int c = 0; c < 16; c++) begin
        if (c == 0) begin
          chk($sformatf("%h b%0d txd", w, k), 32'(uart_txd), 32'(exp_bit(w, k)));
          chk($sformatf("%h b%0d busy", w, k), 32'(tx_busy), 32'd1);
          chk($sformatf("%h b%0d sel", w, k), 32'(byte_sel), 32'(k >= 10));
          chk($sformatf("%h b%0d done", w, k), 32'(tx_done), 32'd0);
        end
        if (c == 15)
          chk($sformatf("%h b%0d txd end", w, k), 32'(uart_txd), 32'(exp_bit(w, k)));
        if (k == inj_k && c == 3) begin
          tx_start = 1'b1;
          tx_data  = 16'hFFFF;
        end else begin
          tx_start = 1'b0;
        end
        @(posedge sys_clk); #1;
      end
    end
    if (stop_k == 20) begin
      chk($sformatf("%h done", w), 32'(tx_done), 32'd1);
      chk($sformatf("%h done busy", w), 32'(tx_busy), 32'd0);
      chk($sformatf("%h done txd", w), 32'(uart_txd), 32'd1);
      chk($sformatf("%h done sel", w), 32'(byte_sel), 32'd0);
    end
  endtask

  initial begin
    int cnt;
    int pulses;

    // reset state
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst txd", 32'(uart_txd), 32'd1);
    chk("rst busy", 32'(tx_busy), 32'd0);
    chk("rst done", 32'(tx_done), 32'd0);
    chk("rst sel", 32'(byte_sel), 32'd0);
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("idle txd", 32'(uart_txd), 32'd1);

    // basic word, done at 320 cycles after the start edge
    start_word(16'hA55A);
    watch_word(16'hA55A, -1, 20);
    @(posedge sys_clk); #1;
    chk("post done pulse", 32'(tx_done), 32'd0);
    chk("post done txd", 32'(uart_txd), 32'd1);

    // stray tx_start with FFFF mid-word must not disturb the word
    start_word(16'hA55A);
    watch_word(16'hA55A, 5, 20);

    // tx_start in the tx_done cycle: next start bit on the following edge
    start_word(16'h0001);
    watch_word(16'h0001, -1, 20);
    @(posedge sys_clk); #1;

    // reset at bit 3 of the high byte aborts the word
    start_word(16'hC3A5);
    watch_word(16'hC3A5, -1, 14);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    chk("abort txd", 32'(uart_txd), 32'd1);
    chk("abort busy", 32'(tx_busy), 32'd0);
    chk("abort done", 32'(tx_done), 32'd0);
    chk("abort sel", 32'(byte_sel), 32'd0);
    sys_rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge sys_clk); #1;
      if (tx_done || !uart_txd) pulses++;
    end
    chk("abort no activity", 32'(pulses), 32'd0);
    start_word(16'h1234);
    watch_word(16'h1234, -1, 20);

    // default rate: start bit is 5208 cycles, first data bit of 00FF is 1
    @(posedge sys_clk); #1;
    d_data  = 16'h00FF;
    d_start = 1'b1;
    @(posedge sys_clk); #1;
    d_start = 1'b0;
    chk("dflt start txd", 32'(d_txd), 32'd0);
    chk("dflt busy", 32'(d_busy), 32'd1);
    cnt = 0;
    while (d_txd == 1'b0 && cnt < 6000) begin
      @(posedge sys_clk); #1;
      cnt++;
    end
    chk("dflt bit width", 32'(cnt), 32'd5208);
    repeat (2604) @(posedge sys_clk);
    #1;
    chk("dflt bit0", 32'(d_txd), 32'd1);
    chk("dflt sel", 32'(d_sel), 32'd0);
    chk("dflt no done", 32'(d_done), 32'd0);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    chk("dflt abort txd", 32'(d_txd), 32'd1);
    chk("dflt abort busy", 32'(d_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
